ws_unit: RTL and testbench
==========================

Name: ws_unit

Overview:
- Write-S unit for the Milestone 2 IDCT datapath; the reverse direction of the fetch-S' path.
- Reads one 8x8 block of computed S values (one signed 32-bit value per word, row-major) from an embedded dual-port RAM read port.
- Clips each value to 8 bits, packs pixel pairs, and writes 32 16-bit words into the Y, U or V segment of the external SRAM at the block position (RB, CB).
- The Milestone 2 controller starts it once per block and multiplexes the SRAM address/we_n/write_data outputs.

Parameters:
- Y_BASE, 18'd0, SRAM word address of the Y segment.
- U_BASE, 18'd38400, SRAM word address of the U segment.
- V_BASE, 18'd57600, SRAM word address of the V segment.
- Y_WORDS_PER_ROW, 9'd160, SRAM words per Y image row (320 pixels).
- UV_WORDS_PER_ROW, 9'd80, SRAM words per U/V image row (160 pixels).
- RAM_BASE, 7'd0, first embedded-RAM address of the S block.

Ports:
- CLOCK_50_I  in  1  50 MHz clock, single clock domain.
- Resetn  in  1  asynchronous active-low reset.
- WS_start  in  1  start pulse, sampled only in IDLE.
- WS_seg  in  2  segment select: 0=Y, 1=U, 2=V (3 treated as V).
- WS_RB  in  5  block row index (0..29).
- WS_CB  in  6  block column index (Y 0..39, U/V 0..19).
- WS_read_address  out  7  embedded RAM read address.
- WS_read_data  in  32  RAM q; valid the cycle after the address is presented.
- SRAM_address  out  18  SRAM word address.
- SRAM_write_data  out  16  packed pixels {even[7:0], odd[7:0]}.
- SRAM_we_n  out  1  active-low SRAM write enable.
- WS_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, WS_read_address=RAM_BASE, WS_done=0, state=IDLE. Reset mid-block aborts immediately with no further writes.
- All outputs are registered.
- States:
  - IDLE: on WS_start=1 at edge E0, latch WS_seg/WS_RB/WS_CB and go to LEAD_IN.
  - LEAD_IN: one cycle, issue k=0.
  - COMMON: issue k=1..63 and perform writes.
  - LEAD_OUT: drain the last write.
  - DONE: assert WS_done for one cycle, then return to IDLE.
- Sample index k = 0..63, with r = k>>3 and c = k&7.
- Read issue: WS_read_address = RAM_BASE + k during cycle k+1 after E0. Data for k is valid in cycle k+2.
- Clip of the signed 32-bit value: bit31=1 -> 8'd0; value > 255 -> 8'd255; else value[7:0].
- Even k: the clipped byte is held in a register.
- Odd k: in cycle k+3, SRAM_we_n=0, SRAM_write_data={held even byte, clipped odd byte}, SRAM_address = base + (RB*8 + r)*W + CB*4 + (c>>1).
  - base and W come from the latched segment.
  - Address arithmetic is 18-bit unsigned; the top-right pixel of the last block addresses exactly base + segment size - 1.
- Writes occur in cycles 4,6,...,66: 32 writes, one every 2 cycles. SRAM_we_n=1 in all other cycles.
- WS_done=1 in cycle 67. WS_start is accepted again from the cycle after WS_done.
- WS_start while not in IDLE is ignored. Input changes after E0 have no effect.
- Inputs outside the index ranges are not checked; addresses wrap mod 2^18.

Test Plan:
- Y, RB=0, CB=0, RAM[k]=k -> 32 writes at addresses 0,1,2,3,160,...,1123; first data 16'h0001, last 16'h3E3F; WS_done in cycle 67.
- Clip: RAM[0]=-5, RAM[1]=300, RAM[2]=255, RAM[3]=0x80000000 -> write0=16'h00FF, write1=16'hFF00.
- U, RB=29, CB=19, RAM all 32'd128 -> first address 38400+232*80+76=57036, last address 57599; all data 16'h8080.
- V, RB=1, CB=2 -> first address 57600+8*80+8=58248; row stride 80.
- WS_start pulsed again at cycle 20, then reset asserted at cycle 30 -> second start has no effect; after reset SRAM_we_n=1, no WS_done; a new start after reset runs a full 32-write block.
- Back-to-back blocks, WS_start asserted in the cycle after WS_done -> second block's first write in cycle 4 of its own run; no missed or extra writes.

Source files
------------

// File: rtl/ws_unit.sv
// ws_unit - Write-S unit for the Milestone 2 IDCT datapath.
//
// Reads one 8x8 block of signed 32-bit S values (row-major) from the
// embedded dual-port RAM, clips every value to an unsigned byte, packs
// horizontally adjacent pixel pairs and writes the 32 resulting words into
// the Y, U or V segment of the external SRAM at block position (RB, CB).
//
// Ports:
//   CLOCK_50_I       - 50 MHz clock
//   Resetn           - asynchronous active-low reset
//   WS_start         - start pulse, only honoured while idle
//   WS_seg           - segment select (0=Y, 1=U, 2/3=V)
//   WS_RB, WS_CB     - block row / block column index
//   WS_read_address  - embedded RAM read address
//   WS_read_data     - embedded RAM q (one cycle after the address)
//   SRAM_address     - SRAM word address
//   SRAM_write_data  - packed pixels {even, odd}
//   SRAM_we_n        - active-low SRAM write enable
//   WS_done          - one-cycle completion pulse
module ws_unit #(
    parameter logic [17:0] Y_BASE           = 18'd0,
    parameter logic [17:0] U_BASE           = 18'd38400,
    parameter logic [17:0] V_BASE           = 18'd57600,
    parameter logic [8:0]  Y_WORDS_PER_ROW  = 9'd160,
    parameter logic [8:0]  UV_WORDS_PER_ROW = 9'd80,
    parameter logic [6:0]  RAM_BASE         = 7'd0
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        WS_start,
    input  logic [1:0]  WS_seg,
    input  logic [4:0]  WS_RB,
    input  logic [5:0]  WS_CB,
    output logic [6:0]  WS_read_address,
    input  logic [31:0] WS_read_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        WS_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_IN,
        S_COMMON,
        S_LEAD_OUT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [1:0]  seg_q, seg_d;
    logic [4:0]  rb_q, rb_d;
    logic [5:0]  cb_q, cb_d;
    logic [7:0]  even_q, even_d;
    logic [6:0]  rd_addr_q, rd_addr_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_n_q, we_n_d;
    logic        done_q, done_d;

    logic [5:0]  k_in;
    logic [7:0]  clip_byte;
    logic [17:0] seg_base;
    logic [17:0] seg_wpr;
    logic [17:0] row_idx;
    logic [17:0] col_idx;
    logic [17:0] wr_addr;

    // cnt_q holds the cycle number since the start edge (1 = LEAD_IN).
    // Data arriving in cycle n belongs to sample k = n - 2.
    assign k_in = cnt_q[5:0] - 6'd2;

    // Negative values clamp to 0, anything above 255 clamps to 255.
    always_comb begin
        if (WS_read_data[31]) begin
            clip_byte = 8'd0;
        end else if (|WS_read_data[30:8]) begin
            clip_byte = 8'd255;
        end else begin
            clip_byte = WS_read_data[7:0];
        end
    end

    // Segment 3 is folded onto V.
    always_comb begin
        case (seg_q)
            2'd0:    begin seg_base = Y_BASE; seg_wpr = {9'd0, Y_WORDS_PER_ROW};  end
            2'd1:    begin seg_base = U_BASE; seg_wpr = {9'd0, UV_WORDS_PER_ROW}; end
            default: begin seg_base = V_BASE; seg_wpr = {9'd0, UV_WORDS_PER_ROW}; end
        endcase
    end

    // Image row = RB*8 + r, word column = CB*4 + c/2, all modulo 2^18.
    assign row_idx = {10'd0, rb_q, 3'd0} + {15'd0, k_in[5:3]};
    assign col_idx = {10'd0, cb_q, 2'd0} + {16'd0, k_in[2:1]};
    assign wr_addr = seg_base + (row_idx * seg_wpr) + col_idx;

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 7'd0;
            seg_q       <= 2'd0;
            rb_q        <= 5'd0;
            cb_q        <= 6'd0;
            even_q      <= 8'd0;
            rd_addr_q   <= RAM_BASE;
            sram_addr_q <= 18'd0;
            wdata_q     <= 16'd0;
            we_n_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seg_q       <= seg_d;
            rb_q        <= rb_d;
            cb_q        <= cb_d;
            even_q      <= even_d;
            rd_addr_q   <= rd_addr_d;
            sram_addr_q <= sram_addr_d;
            wdata_q     <= wdata_d;
            we_n_q      <= we_n_d;
            done_q      <= done_d;
        end
    end

    // Next state: LEAD_IN covers cycle 1, COMMON cycles 2..64,
    // LEAD_OUT cycles 65..66, DONE cycle 67.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (WS_start) state_d = S_LEAD_IN;
            S_LEAD_IN:  state_d = S_COMMON;
            S_COMMON:   if (cnt_q == 7'd64) state_d = S_LEAD_OUT;
            S_LEAD_OUT: if (cnt_q == 7'd66) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath registers for the next cycle.
    always_comb begin
        cnt_d       = cnt_q;
        seg_d       = seg_q;
        rb_d        = rb_q;
        cb_d        = cb_q;
        even_d      = even_q;
        rd_addr_d   = rd_addr_q;
        sram_addr_d = sram_addr_q;
        wdata_d     = wdata_q;
        we_n_d      = 1'b1;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (WS_start) begin
                    seg_d     = WS_seg;
                    rb_d      = WS_RB;
                    cb_d      = WS_CB;
                    cnt_d     = 7'd1;
                    rd_addr_d = RAM_BASE;
                end
            end
            S_LEAD_IN, S_COMMON, S_LEAD_OUT: begin
                cnt_d = cnt_q + 7'd1;
                // In cycle n the address for sample k = n goes out next.
                if (state_q != S_LEAD_OUT && cnt_q < 7'd64) begin
                    rd_addr_d = RAM_BASE + cnt_q;
                end
                if (state_q != S_LEAD_IN && cnt_q <= 7'd65) begin
                    if (!k_in[0]) begin
                        even_d = clip_byte;
                    end else begin
                        we_n_d      = 1'b0;
                        wdata_d     = {even_q, clip_byte};
                        sram_addr_d = wr_addr;
                    end
                end
                if (state_q == S_LEAD_OUT && cnt_q == 7'd66) begin
                    done_d = 1'b1;
                end
            end
            S_DONE: begin
                cnt_d     = 7'd0;
                rd_addr_d = RAM_BASE;
            end
            default: ;
        endcase
    end

    assign WS_read_address = rd_addr_q;
    assign SRAM_address    = sram_addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign WS_done         = done_q;

endmodule

// File: tb/tb_ws_unit.sv
// tb_ws_unit - directed self-checking bench for ws_unit.
//
// A behavioural embedded RAM feeds the unit; each block run is checked
// cycle by cycle against a pixel-coordinate address model and a clip model,
// and selected writes are also compared to hand-computed constants.
module tb_ws_unit;

    logic        clk;
    logic        rst_n;
    logic        WS_start;
    logic [1:0]  WS_seg;
    logic [4:0]  WS_RB;
    logic [5:0]  WS_CB;
    logic [6:0]  WS_read_address;
    logic [31:0] WS_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        WS_done;

    logic [31:0] mem [0:127];

    int checks;
    int errors;
    int obs_writes;
    logic [17:0] first_addr, last_addr, addr4;
    logic [15:0] first_data, last_data;
    logic [15:0] wr_data [0:31];

    ws_unit dut (
        .CLOCK_50_I      (clk),
        .Resetn          (rst_n),
        .WS_start        (WS_start),
        .WS_seg          (WS_seg),
        .WS_RB           (WS_RB),
        .WS_CB           (WS_CB),
        .WS_read_address (WS_read_address),
        .WS_read_data    (WS_read_data),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .WS_done         (WS_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Synchronous-read embedded RAM: q is valid the cycle after the address.
    always @(posedge clk) WS_read_data <= mem[WS_read_address];

    function automatic logic [7:0] clip8(input logic [31:0] v);
        if (v[31]) return 8'h00;
        if (v > 32'd255) return 8'hFF;
        return v[7:0];
    endfunction

    // Address from pixel coordinates: word = base + y*W + x/2.
    function automatic logic [17:0] expAddr(input logic [1:0] seg, input int rb,
                                            input int cb, input int k);
        int base, w, prow, pcol, a;
        case (seg)
            2'd0:    begin base = 0;     w = 160; end
            2'd1:    begin base = 38400; w = 80;  end
            default: begin base = 57600; w = 80;  end
        endcase
        prow = rb * 8 + k / 8;
        pcol = cb * 8 + k % 8;
        a = base + prow * w + pcol / 2;
        return a[17:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one block; optionally re-pulses start in cycle 'repulse' and
    // asserts reset in cycle 'abort_at' (0 disables either).
    task automatic applyStimulus(input logic [1:0] seg, input logic [4:0] rb,
                                 input logic [5:0] cb, input int repulse,
                                 input int abort_at);
        logic        exp_we;
        int          k;
        int          widx;
        obs_writes = 0;
        widx = 0;
        @(negedge clk);
        WS_seg = seg; WS_RB = rb; WS_CB = cb; WS_start = 1'b1;
        @(negedge clk);
        WS_start = 1'b0; WS_seg = ~seg; WS_RB = ~rb; WS_CB = ~cb;
        for (int n = 1; n <= 67; n++) begin
            if (n > 1) @(negedge clk);
            exp_we = !((n % 2 == 0) && (n >= 4) && (n <= 66));
            if (SRAM_we_n === 1'b0) obs_writes++;
            checkOutput("we_n", {31'd0, SRAM_we_n}, {31'd0, exp_we});
            if (!exp_we) begin
                k = n - 3;
                checkOutput("addr", {14'd0, SRAM_address}, {14'd0, expAddr(seg, rb, cb, k)});
                checkOutput("data", {16'd0, SRAM_write_data},
                            {16'd0, clip8(mem[k - 1]), clip8(mem[k])});
                wr_data[widx] = SRAM_write_data;
                if (widx == 0) begin
                    first_addr = SRAM_address;
                    first_data = SRAM_write_data;
                end
                if (widx == 4) addr4 = SRAM_address;
                last_addr = SRAM_address;
                last_data = SRAM_write_data;
                widx++;
            end
            checkOutput("done", {31'd0, WS_done}, {31'd0, (n == 67)});
            WS_start = (n == repulse);
            if (n == abort_at) begin
                rst_n = 1'b0;
                break;
            end
        end
        WS_start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        WS_start = 1'b0;
        WS_seg = 2'd0;
        WS_RB = 5'd0;
        WS_CB = 6'd0;
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
        checkOutput("rst_addr", {14'd0, SRAM_address}, 32'd0);
        checkOutput("rst_wdata", {16'd0, SRAM_write_data}, 32'd0);
        checkOutput("rst_raddr", {25'd0, WS_read_address}, 32'd0);
        checkOutput("rst_done", {31'd0, WS_done}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] Y block RB=0 CB=0 ramp data");
        for (int i = 0; i < 64; i++) mem[i] = i;
        applyStimulus(2'd0, 5'd0, 6'd0, 0, 0);
        checkOutput("y_first_addr", {14'd0, first_addr}, 32'd0);
        checkOutput("y_first_data", {16'd0, first_data}, 32'h0001);
        checkOutput("y_row1_addr", {14'd0, addr4}, 32'd160);
        checkOutput("y_last_addr", {14'd0, last_addr}, 32'd1123);
        checkOutput("y_last_data", {16'd0, last_data}, 32'h3E3F);
        checkOutput("y_writes", obs_writes, 32'd32);

        $display("[TB] clip boundaries");
        mem[0] = -32'sd5;
        mem[1] = 32'd300;
        mem[2] = 32'd255;
        mem[3] = 32'h8000_0000;
        applyStimulus(2'd0, 5'd3, 6'd5, 0, 0);
        checkOutput("clip_w0", {16'd0, wr_data[0]}, 32'h00FF);
        checkOutput("clip_w1", {16'd0, wr_data[1]}, 32'hFF00);

        $display("[TB] U block RB=29 CB=19");
        for (int i = 0; i < 64; i++) mem[i] = 32'd128;
        applyStimulus(2'd1, 5'd29, 6'd19, 0, 0);
        checkOutput("u_first_addr", {14'd0, first_addr}, 32'd57036);
        checkOutput("u_last_addr", {14'd0, last_addr}, 32'd57599);
        checkOutput("u_last_data", {16'd0, last_data}, 32'h8080);

        $display("[TB] V block RB=1 CB=2");
        for (int i = 0; i < 64; i++) mem[i] = 32'd1000 - 32'(i * 20);
        applyStimulus(2'd2, 5'd1, 6'd2, 0, 0);
        checkOutput("v_first_addr", {14'd0, first_addr}, 32'd58248);
        checkOutput("v_row1_addr", {14'd0, addr4}, 32'd58328);

        $display("[TB] segment 3 maps to V");
        applyStimulus(2'd3, 5'd0, 6'd0, 0, 0);
        checkOutput("s3_first_addr", {14'd0, first_addr}, 32'd57600);

        $display("[TB] restart ignored, then reset mid-block");
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 3);
        applyStimulus(2'd0, 5'd1, 6'd1, 20, 30);
        #1;
        checkOutput("abort_we_n", {31'd0, SRAM_we_n}, 32'd1);
        checkOutput("abort_addr", {14'd0, SRAM_address}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        obs_writes = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (SRAM_we_n === 1'b0) obs_writes++;
            checkOutput("idle_done", {31'd0, WS_done}, 32'd0);
        end
        checkOutput("idle_writes", obs_writes, 32'd0);
        applyStimulus(2'd0, 5'd1, 6'd1, 0, 0);
        checkOutput("post_rst_writes", obs_writes, 32'd32);

        $display("[TB] back-to-back blocks");
        applyStimulus(2'd0, 5'd2, 6'd3, 0, 0);
        checkOutput("b2b_a_writes", obs_writes, 32'd32);
        applyStimulus(2'd1, 5'd4, 6'd5, 0, 0);
        checkOutput("b2b_b_writes", obs_writes, 32'd32);
        checkOutput("b2b_b_first", {14'd0, first_addr}, 32'd38400 + 32'd32 * 32'd80 + 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
